gate_sweep_ctrl: RTL and testbench

//  Sequencer for an N-input combinational gate under test (e.g. nand_3).
//  On start, walks the gate's inputs through all 2**N_IN combinations in

---
 rtl/gate_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep of an N_IN-input combinational gate: steps the
// inputs through every vector, samples the gate output and scores it against EXPECT.
module gate_sweep_ctrl #(
   parameter int unsigned          N_IN       = 3,
   parameter int unsigned          SETTLE_CYC = 2,
   parameter logic [(1<<N_IN)-1:0] EXPECT     = 8'b0111_1111
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   output logic [N_IN-1:0]        gate_in,
   input  logic                   gate_out,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [(1<<N_IN)-1:0]   result,
   output logic [N_IN:0]          err_cnt
);

   localparam int unsigned     NVEC     = 1 << N_IN;
   localparam int unsigned     CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [N_IN-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N_IN-1:0]   gate_in_d;
   logic              busy_d, done_d, pass_d;
   logic [NVEC-1:0]   result_d;
   logic [N_IN:0]     err_d, err_inc;
   logic              mismatch;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      gate_in_d = gate_in;
      busy_d    = busy;
      done_d    = 1'b0;
      pass_d    = pass;
      result_d  = result;
      err_d     = err_cnt;
      mismatch  = (gate_out != EXPECT[idx_q]);
      err_inc   = err_cnt + {{N_IN{1'b0}}, mismatch};

      unique case (state_q)
         S_IDLE, S_DONE: begin
            // Start wins over a simultaneous abort here; abort is meaningless outside RUN.
            if (start) begin
               state_d   = S_RUN;
               idx_d     = '0;
               cnt_d     = '0;
               gate_in_d = '0;
               busy_d    = 1'b1;
               pass_d    = 1'b0;
               result_d  = '0;
               err_d     = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               // A sample due on this edge is dropped; partial result/err_cnt stay visible.
               state_d   = S_IDLE;
               idx_d     = '0;
               cnt_d     = '0;
               gate_in_d = '0;
               busy_d    = 1'b0;
               pass_d    = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               result_d[idx_q] = gate_out;
               err_d           = err_inc;
               cnt_d           = '0;
               if (idx_q == IDX_LAST) begin
                  state_d   = S_DONE;
                  idx_d     = '0;
                  gate_in_d = '0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  pass_d    = (err_inc == '0);
               end else begin
                  idx_d     = idx_q + 1'b1;
                  gate_in_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         gate_in <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         result  <= '0;
         err_cnt <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         gate_in <= gate_in_d;
         busy    <= busy_d;
         done    <= done_d;
         pass    <= pass_d;
         result  <= result_d;
         err_cnt <= err_d;
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (defaults, and N_IN=2/SETTLE_CYC=1)
// driven by a table-defined gate and scored against truth-table arithmetic.
module tb_gate_sweep_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   localparam logic [7:0] EXP_A = 8'b0111_1111;
   localparam logic [3:0] EXP_B = 4'b0111;

   // Instance A: defaults (3-input NAND, settle 2)
   logic       start, abort, gate_out, busy, done, pass;
   logic [2:0] gate_in;
   logic [7:0] result;
   logic [3:0] err_cnt;
   logic [7:0] gate_tbl;
   assign gate_out = gate_tbl[gate_in];

   // Instance B: 2-input, settle 1
   logic       start2, abort2, gate_out2, busy2, done2, pass2;
   logic [1:0] gate_in2;
   logic [3:0] result2;
   logic [2:0] err_cnt2;
   logic [3:0] gate_tbl2;
   assign gate_out2 = gate_tbl2[gate_in2];

   gate_sweep_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
      .pass(pass), .result(result), .err_cnt(err_cnt)
   );

   gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(1), .EXPECT(4'b0111)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
      .gate_in(gate_in2), .gate_out(gate_out2), .busy(busy2), .done(done2),
      .pass(pass2), .result(result2), .err_cnt(err_cnt2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] low_mask(input int n);
      return (32'd1 << n) - 32'd1;
   endfunction

   // Full sweep on A; optional start pulse mid-sweep which must be ignored.
   task automatic sweep_a(input logic [7:0] tbl, input bit poke);
      int errs;
      errs     = $countones(tbl ^ EXP_A);
      gate_tbl = tbl;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_gate_in", gate_in, 0);
      check("start_result_clr", result, 0);
      check("start_err_clr", err_cnt, 0);
      check("start_pass_clr", pass, 0);
      for (int c = 1; c <= 16; c++) begin
         start = poke && (c == 6);
         tick();
         if (c < 16) begin
            check("gate_in_step", gate_in, c / 2);
            check("busy_run", busy, 1);
            check("done_early", done, 0);
         end
      end
      start = 1'b0;
      check("done_pulse", done, 1);
      check("busy_end", busy, 0);
      check("gate_in_end", gate_in, 0);
      check("result", result, tbl);
      check("err_cnt", err_cnt, errs);
      check("pass", pass, errs == 0);
      tick();
      check("done_clear", done, 0);
      check("result_hold", result, tbl);
      check("err_hold", err_cnt, errs);
      check("pass_hold", pass, errs == 0);
   endtask

   // Abort seen at edge start+c_ab+1; c_ab/2 vectors have been sampled by then.
   task automatic abort_a(input logic [7:0] tbl, input int c_ab);
      int         n;
      logic [7:0] m;
      n        = c_ab / 2;
      m        = 8'(low_mask(n));
      gate_tbl = tbl;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (c_ab) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_gate_in", gate_in, 0);
      check("abort_done", done, 0);
      check("abort_pass", pass, 0);
      check("abort_result", result, tbl & m);
      check("abort_err", err_cnt, $countones((tbl ^ EXP_A) & m));
      repeat (18) begin
         tick();
         check("abort_no_done", done, 0);
      end
      check("abort_result_hold", result, tbl & m);
   endtask

   // Start held high through the end of a sweep restarts it straight from DONE.
   task automatic back_to_back(input logic [7:0] tbl);
      int errs;
      errs     = $countones(tbl ^ EXP_A);
      gate_tbl = tbl;
      start = 1'b1;
      repeat (17) tick();
      check("b2b_done1", done, 1);
      check("b2b_result1", result, tbl);
      tick();
      start = 1'b0;
      check("b2b_restart_busy", busy, 1);
      check("b2b_restart_done", done, 0);
      check("b2b_restart_result", result, 0);
      check("b2b_restart_err", err_cnt, 0);
      check("b2b_restart_pass", pass, 0);
      repeat (16) tick();
      check("b2b_done2", done, 1);
      check("b2b_result2", result, tbl);
      check("b2b_err2", err_cnt, errs);
      tick();
   endtask

   task automatic sweep_b(input logic [3:0] tbl);
      int errs;
      errs      = $countones(tbl ^ EXP_B);
      gate_tbl2 = tbl;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("b_start_busy", busy2, 1);
      check("b_start_gate_in", gate_in2, 0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c < 4) begin
            check("b_gate_in_step", gate_in2, c);
            check("b_done_early", done2, 0);
         end
      end
      check("b_done_pulse", done2, 1);
      check("b_busy_end", busy2, 0);
      check("b_result", result2, tbl);
      check("b_err_cnt", err_cnt2, errs);
      check("b_pass", pass2, errs == 0);
      tick();
      check("b_done_clear", done2, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_gate_in"}, gate_in, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_err"}, err_cnt, 0);
      check({tag, "_b_busy"}, busy2, 0);
      check({tag, "_b_result"}, result2, 0);
      check({tag, "_b_err"}, err_cnt2, 0);
      check({tag, "_b_gate_in"}, gate_in2, 0);
   endtask

   initial begin
      start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
      gate_tbl = EXP_A; gate_tbl2 = EXP_B;

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed cases
      sweep_a(8'h7F, 1'b0);
      sweep_a(8'hFF, 1'b0);
      sweep_a(8'h00, 1'b0);
      sweep_a(8'hFE, 1'b0);
      abort_a(8'h7F, 8);
      abort_a(8'h7E, 15);
      sweep_a(8'h7F, 1'b1);
      back_to_back(8'h7F);

      // Abort in DONE does nothing; abort+start in DONE starts
      sweep_a(8'h3F, 1'b0);
      abort = 1'b1;
      tick();
      check("done_abort_busy", busy, 0);
      check("done_abort_result", result, 8'h3F);
      check("done_abort_err", err_cnt, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_beats_abort", busy, 1);
      repeat (16) tick();
      check("start_beats_abort_done", done, 1);
      check("start_beats_abort_res", result, 8'h3F);
      tick();

      sweep_b(4'b0111);
      sweep_b(4'b0000);

      // Reset mid-sweep
      gate_tbl = 8'h7F;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst_mid");
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         tick();
         check("rst_no_done", done, 0);
      end

      // Randomized mix against the truth-table model
      for (int it = 0; it < 30; it++) begin
         logic [7:0] tbl;
         tbl = ($urandom_range(0, 1) == 0) ? EXP_A : 8'($urandom);
         case ($urandom_range(0, 3))
            0: sweep_a(tbl, 1'($urandom_range(0, 1)));
            1: abort_a(tbl, int'($urandom_range(1, 15)));
            2: sweep_b(4'($urandom));
            default: back_to_back(tbl);
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
